uart_msg_gen: RTL and testbench

- Parametrised successor to the fixed-string TX data memory.
- On a start pulse, captures a binary value, converts it to decimal ASCII, and streams the line "rate:<digits><EOL>" byte by byte to the UART transmitter over a valid/ready handshake.
- Replaces free-running edge-triggered indexing with a single-clock FSM that tolerates transmitter backpressure.
- Sits between the rate/state control logic and the UART TX serializer.

---
 rtl/uart_msg_gen_if.sv | 23 ++
 rtl/uart_msg_gen.sv | 168 ++++++++++++++++
 tb/tb_uart_msg_gen.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/uart_msg_gen_if.sv
// Start/value request and byte-stream handshake between rate control, uart_msg_gen and the UART TX.
// master = message generator side, slave = requester / transmitter side.
interface uart_msg_gen_if #(
  parameter int VAL_W = 16
);
  logic             iSTART;
  logic [VAL_W-1:0] iVALUE;
  logic             iTX_READY;
  logic             oTX_VALID;
  logic [7:0]       oTX_DATA;
  logic             oBUSY;
  logic             oDONE;

  modport master (
    input  iSTART, iVALUE, iTX_READY,
    output oTX_VALID, oTX_DATA, oBUSY, oDONE
  );

  modport slave (
    output iSTART, iVALUE, iTX_READY,
    input  oTX_VALID, oTX_DATA, oBUSY, oDONE
  );
endinterface

// File: rtl/uart_msg_gen.sv
// Converts a captured binary value to decimal and streams "rate:<digits><EOL>" over valid/ready.
// Optional macro LEAD_ZERO_SUPPRESS_EN: skip leading '0' digits (least significant digit always sent).

// Per-digit double-dabble correction: add 3 to a nibble >= 5 before the shift.
module uart_msg_gen_dd (
  input  logic [3:0] nib,
  output logic [3:0] adj
);
  assign adj = (nib >= 4'd5) ? nib + 4'd3 : nib;
endmodule

module uart_msg_gen #(
  parameter int         VAL_W      = 16,
  parameter int         NUM_DIGITS = 5,
  parameter logic [7:0] EOL_CHAR   = 8'h0A,
  parameter logic [7:0] IDLE_DATA  = 8'hFF
) (
  input logic clk,
  input logic reset,
  uart_msg_gen_if.master bus
);
  localparam int LAST = 5 + NUM_DIGITS;
  localparam int IDXW = $clog2(LAST + 1);
  localparam int CW   = $clog2(VAL_W + 1);
  localparam int BW   = NUM_DIGITS * 4;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LAST);
  localparam logic [IDXW-1:0] PRE_LAST = IDXW'(4);
  localparam logic [CW-1:0]   CNT_LAST = CW'(VAL_W - 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] POW10 = pow10(NUM_DIGITS);
  localparam logic [63:0] MAXV  = (64'd1 << VAL_W) - 64'd1;

  typedef enum logic [2:0] {IDLE, CONVERT, PREFIX, DIGITS, EOL, DONE} state_t;

  state_t                       state, stateN;
  logic [VAL_W-1:0]             valReg, valN;
  logic [NUM_DIGITS-1:0][3:0]   bcd, bcdN, bcdAdj;
  logic [BW-1:0]                adjFlat;
  logic [CW-1:0]                bitCnt, bitCntN;
  logic [IDXW-1:0]              byteIdx, idxN, nextIdx, firstDig;
  logic                         txValid, vldN;
  logic [7:0]                   txData, dataN;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : gDd
    uart_msg_gen_dd uDd (.nib(bcd[g]), .adj(bcdAdj[g]));
  end
  assign adjFlat = bcdAdj;

  // Byte at a message index: 0..4 prefix, then digits MS first, then EOL.
  function automatic logic [7:0] byteOf(input logic [IDXW-1:0] idx,
                                        input logic [NUM_DIGITS-1:0][3:0] b);
    logic [7:0] r;
    r = EOL_CHAR;
    case (int'(idx))
      0: r = 8'h72;
      1: r = 8'h61;
      2: r = 8'h74;
      3: r = 8'h65;
      4: r = 8'h3A;
      default: ;
    endcase
    for (int d = 0; d < NUM_DIGITS; d++)
      if (int'(idx) == 5 + d) r = 8'h30 + {4'h0, b[NUM_DIGITS-1-d]};
    return r;
  endfunction

  function automatic state_t phaseOf(input logic [IDXW-1:0] idx);
    if (idx <= PRE_LAST)     return PREFIX;
    else if (idx < LAST_IDX) return DIGITS;
    else                     return EOL;
  endfunction

  // Index of the first digit sent after the prefix.
  always_comb begin
    firstDig = IDXW'(5);
`ifdef LEAD_ZERO_SUPPRESS_EN
    firstDig = LAST_IDX - IDXW'(1);
    for (int d = NUM_DIGITS - 2; d >= 0; d--)
      if (bcd[NUM_DIGITS-1-d] != 4'h0) firstDig = IDXW'(5 + d);
`endif
  end

  always_comb begin
    if (byteIdx == PRE_LAST)      nextIdx = firstDig;
    else if (byteIdx >= LAST_IDX) nextIdx = LAST_IDX;
    else                          nextIdx = byteIdx + IDXW'(1);
  end

  always_comb begin
    stateN  = state;
    valN    = valReg;
    bcdN    = bcd;
    bitCntN = bitCnt;
    idxN    = byteIdx;
    vldN    = txValid;
    dataN   = txData;
    case (state)
      IDLE: if (bus.iSTART) begin
        valN    = bus.iVALUE;
        bcdN    = '0;
        bitCntN = '0;
        idxN    = '0;
        stateN  = CONVERT;
      end
      CONVERT: begin
        bcdN = BW'({adjFlat, valReg[VAL_W-1]});
        valN = valReg << 1;
        if (bitCnt == CNT_LAST) stateN = PREFIX;
        else                    bitCntN = bitCnt + CW'(1);
      end
      PREFIX, DIGITS, EOL: begin
        // First byte loads from the idle bus; later ones replace the byte just transferred.
        if (!txValid) begin
          vldN  = 1'b1;
          dataN = byteOf(byteIdx, bcd);
        end else if (bus.iTX_READY) begin
          if (byteIdx == LAST_IDX) begin
            vldN   = 1'b0;
            dataN  = IDLE_DATA;
            stateN = DONE;
          end else begin
            idxN   = nextIdx;
            dataN  = byteOf(nextIdx, bcd);
            stateN = phaseOf(nextIdx);
          end
        end
      end
      DONE:    stateN = IDLE;
      default: stateN = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      valReg  <= '0;
      bcd     <= '0;
      bitCnt  <= '0;
      byteIdx <= '0;
      txValid <= 1'b0;
      txData  <= IDLE_DATA;
    end else begin
      state   <= stateN;
      valReg  <= valN;
      bcd     <= bcdN;
      bitCnt  <= bitCntN;
      byteIdx <= idxN;
      txValid <= vldN;
      txData  <= dataN;
    end
  end

  assign bus.oTX_VALID = txValid;
  assign bus.oTX_DATA  = txData;
  assign bus.oBUSY     = (state != IDLE);
  assign bus.oDONE     = (state == DONE);

`ifndef SYNTHESIS
  a_digits_fit: assert property (@(posedge clk) POW10 > MAXV);
`endif
endmodule

// File: tb/tb_uart_msg_gen.sv
// Self-checking bench for uart_msg_gen: table of messages plus reset / start-collision sequences.
module tb_uart_msg_gen;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_msg_gen_if #(.VAL_W(16)) bus ();
  uart_msg_gen #(.VAL_W(16), .NUM_DIGITS(5), .EOL_CHAR(8'h0A), .IDLE_DATA(8'hFF))
    dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [15:0] val;
    logic [39:0] digs;   // five ASCII digits, zero padded
    int          mode;   // 0 ready, 1 toggle, 2 random, 3 stall on byte 6
    int          extra;  // 0 none, 1 second start in PREFIX, 2 start during DONE
  } vec_t;

  int checks = 0, errors = 0;
  int rdyMode = 0, stallLeft = 0;
  int xferCnt = 0, doneCnt = 0, idx6Cyc = 0;
  logic [7:0] expQ[$];
  logic       prevPend = 1'b0, prevDone = 1'b0;
  logic [7:0] prevData = 8'h00;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pushExp(input logic [39:0] digs);
    logic [7:0] c;
    logic       lead;
    logic [39:0] pre;
    pre  = "rate:";
    lead = 1'b1;
    for (int i = 0; i < 5; i++) expQ.push_back(pre[39-8*i -: 8]);
    for (int i = 0; i < 5; i++) begin
      c = digs[39-8*i -: 8];
`ifdef LEAD_ZERO_SUPPRESS_EN
      if (lead && c == "0" && i < 4) continue;
`endif
      lead = 1'b0;
      expQ.push_back(c);
    end
    expQ.push_back(8'h0A);
  endtask

  // Ready generator, changes #1 after each rising edge.
  always @(posedge clk) begin
    #1;
    case (rdyMode)
      0: bus.iTX_READY = 1'b1;
      1: bus.iTX_READY = ~bus.iTX_READY;
      2: bus.iTX_READY = 1'($urandom_range(0, 1));
      default: begin
        if (xferCnt == 6 && stallLeft > 0) begin
          bus.iTX_READY = 1'b0;
          stallLeft--;
        end else bus.iTX_READY = 1'b1;
      end
    endcase
  end

  // Monitor: a transfer happens at the next rising edge when valid && ready here.
  always @(negedge clk) begin
    if (reset) begin
      prevPend = 1'b0;
      prevDone = 1'b0;
    end else begin
      if (prevPend) chk("hold", int'({bus.oTX_VALID, bus.oTX_DATA}), int'({1'b1, prevData}));
      if (!bus.oTX_VALID) chk("idle_data", int'(bus.oTX_DATA), 'hFF);
      if (bus.oTX_VALID && xferCnt == 6) idx6Cyc++;
      if (bus.oTX_VALID && bus.iTX_READY) begin
        if (expQ.size() == 0) chk("extra_byte", int'(bus.oTX_DATA), -1);
        else begin
          chk("byte", int'(bus.oTX_DATA), int'(expQ[0]));
          void'(expQ.pop_front());
        end
        xferCnt++;
      end
      if (bus.oDONE) begin
        chk("done_pulse", int'(prevDone), 0);
        doneCnt++;
      end
      prevPend = bus.oTX_VALID && !bus.iTX_READY;
      prevData = bus.oTX_DATA;
      prevDone = bus.oDONE;
    end
  end

  task automatic startMsg(input logic [15:0] v);
    @(posedge clk); #1;
    bus.iSTART = 1'b1;
    bus.iVALUE = v;
    @(posedge clk); #1;
    bus.iSTART = 1'b0;
    bus.iVALUE = 16'($urandom);
  endtask

  task automatic runMsg(input logic [15:0] v, input logic [39:0] digs, input int mode, input int extra);
    int lat, n, d0, nb;
    pushExp(digs);
    nb = expQ.size();
    rdyMode = mode; stallLeft = 3; xferCnt = 0; idx6Cyc = 0; d0 = doneCnt;
    startMsg(v);
    lat = 0;
    while (lat < 100 && !bus.oTX_VALID) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 17);
    if (extra == 1) begin
      bus.iSTART = 1'b1;
      bus.iVALUE = 16'd9;
      @(posedge clk); #1;
      bus.iSTART = 1'b0;
    end
    n = 0;
    while (doneCnt == d0 && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("done_timeout", int'(n < 3000), 1);
    if (extra == 2) begin
      bus.iSTART = 1'b1;
      @(posedge clk); #1;
      bus.iSTART = 1'b0;
      @(negedge clk);
      chk("start_in_done_busy", int'(bus.oBUSY), 0);
    end
    repeat (extra == 1 ? 40 : 3) @(negedge clk);
    chk("busy_after", int'(bus.oBUSY), 0);
    chk("done_count", doneCnt - d0, 1);
    chk("bytes_sent", xferCnt, nb);
    chk("queue_empty", expQ.size(), 0);
    if (mode == 3) chk("stall_hold_cycles", idx6Cyc, 4);
  endtask

  vec_t vecs[8];

  initial begin
    int n, d0;
    vecs[0] = '{16'd1234,  "01234", 0, 0};
    vecs[1] = '{16'd0,     "00000", 0, 0};
    vecs[2] = '{16'd65535, "65535", 3, 0};
    vecs[3] = '{16'd42,    "00042", 1, 0};
    vecs[4] = '{16'd9,     "00009", 2, 2};
    vecs[5] = '{16'd1234,  "01234", 0, 1};
    vecs[6] = '{16'd10000, "10000", 2, 0};
    vecs[7] = '{16'd99,    "00099", 1, 0};

    reset = 1'b1;
    bus.iSTART = 1'b0;
    bus.iVALUE = '0;
    bus.iTX_READY = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(bus.oTX_VALID), 0);
    chk("rst_data",  int'(bus.oTX_DATA), 'hFF);
    chk("rst_busy",  int'(bus.oBUSY), 0);
    chk("rst_done",  int'(bus.oDONE), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (vecs[i]) runMsg(vecs[i].val, vecs[i].digs, vecs[i].mode, vecs[i].extra);

    // Reset while byte index 7 is pending.
    pushExp("01234");
    rdyMode = 0; xferCnt = 0; d0 = doneCnt;
    startMsg(16'd1234);
    n = 0;
    while (xferCnt < 7 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk("mid_timeout", int'(n < 200), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", int'(bus.oTX_VALID), 0);
    chk("mid_rst_data",  int'(bus.oTX_DATA), 'hFF);
    chk("mid_rst_busy",  int'(bus.oBUSY), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    expQ.delete();
    repeat (5) @(negedge clk);
    chk("mid_rst_no_done", doneCnt - d0, 0);
    runMsg(16'd1234, "01234", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
